spi_slave_burst: RTL
====================

# spi_slave_burst

Parametrised SPI slave for the AES datapath interface, successor to the fixed 16-bit, mode-0-only slave. Runs entirely in the system clock domain: SCLK, CS and SDI are synchronised and edge-detected, so no logic is clocked by SCLK. Supports all four SPI modes, MSB/LSB-first order and back-to-back words within one CS frame. TX data is double-buffered via a valid/ready handshake; each received word is presented with a one-cycle strobe.

## Interface
Parameters:
- DATA_W, 16: word width in bits, 2..128 (AES block = 128)
- CPOL, 0: SCLK idle level
- CPHA, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing
- LSB_FIRST, 1: 1 = bit 0 first on both SDI and SDO

Ports:
- CLK  in  1  system clock; all logic on posedge CLK
- RST  in  1  reset, synchronous, active-high
- SCLK  in  1  SPI clock from master (asynchronous)
- CS  in  1  chip select, active-low (asynchronous)
- SDI  in  1  serial data in (asynchronous)
- SDO  out  1  serial data out
- DATA_IN  in  DATA_W  next TX word
- DATA_VALID  in  1  DATA_IN valid
- TX_READY  out  1  TX holding register empty
- DATA_OUT  out  DATA_W  last complete RX word
- RX_VALID  out  1  one-cycle strobe, DATA_OUT updated this cycle
- DONE  out  1  one-cycle strobe on frame end (synchronised CS rise)
- UNDERRUN  out  1  one-cycle strobe: word boundary with TX holding empty
- PARTIAL  out  1  one-cycle strobe with DONE if frame ended mid-word

## Operation
- Sync: 2-FF synchroniser on SCLK, CS, SDI; one extra register on SCLK for edge detect. Leading edge = SCLK leaving CPOL level.
- TX holding register: load when DATA_VALID && TX_READY; TX_READY low while full. Accepted in any state.
- States: ARM (wait synced CS high), IDLE (CS high), ACTIVE (CS low).
- ARM -> IDLE when synced CS = 1. Entered from reset so a frame already in progress at reset release is ignored.
- IDLE -> ACTIVE on synced CS fall: shift register <= holding register (holding emptied, TX_READY rises next cycle); if holding empty load all-zero and pulse UNDERRUN. Bit counter <= 0.
- ACTIVE, sample edge: shift synced SDI into RX shift register at end selected by LSB_FIRST; counter++. On counter reaching DATA_W: DATA_OUT <= assembled word, RX_VALID = 1, counter <= 0, TX shift register reloaded from holding (same underrun rule).
- ACTIVE, shift edge: TX shift register advances one bit, except the CPHA=1 first leading edge of each word (bit already on SDO). For CPHA=0 the reload at the word boundary presents the new first bit; the following trailing edge does not shift.
- SDO = current first-order bit of TX shift register (bit 0 if LSB_FIRST, else bit DATA_W-1); driven 0 in ARM/IDLE.
- ACTIVE -> IDLE on synced CS rise: DONE = 1; PARTIAL = 1 if counter != 0; partial RX bits discarded, DATA_OUT unchanged; holding register kept.
- Simultaneous CS rise and final sample edge in same cycle: sample completes word (RX_VALID), then DONE with PARTIAL = 0.
- Simultaneous DATA_VALID and word-boundary reload: reload sees old holding state; new word is written to holding in the same cycle.

## Timing
- Reset values: SDO 0, TX_READY 1, DATA_OUT 0, RX_VALID 0, DONE 0, UNDERRUN 0, PARTIAL 0, state ARM, counter 0.
- Input-to-action latency: 3 CLK from SCLK/CS pin edge to internal edge pulse.
- SDO valid ≤ 4 CLK after pin shift edge, hence SCLK high and low times each ≥ 4 CLK (SCLK ≤ CLK/8).
- CPHA=0: master must allow ≥ 4 CLK from CS fall to first SCLK edge.
- RX_VALID asserted 3 CLK after the DATA_W-th sample edge at the pin.
- Bit counter width $clog2(DATA_W+1); wraps to 0 at each word boundary; unlimited words per frame.

## Structure
- Shared header spi_defs.vh: state encodings (ARM, IDLE, ACTIVE), mode helper constants.
- One sub-module: spi_sync_2ff (1-bit double-flop synchroniser, reset to parameter value; CS resets to 1, SCLK to CPOL).
- Top holds edge detect, FSM, counter, TX holding/shift, RX shift.

## Test plan
- Mode 0, DATA_W=16, LSB first: DATA_IN=16'hA5C3 loaded, master sends 16'h1234 -> SDO stream = A5C3 LSB first, DATA_OUT=16'h1234, one RX_VALID, DONE, PARTIAL=0.
- Modes 1/2/3 and LSB_FIRST=0 with DATA_W=128: AES block 128'h00112233...EEFF round-trip equals master's captured word.
- Burst: 3 words in one frame, holding refilled after each TX_READY -> 3 RX_VALID strobes, correct order, UNDERRUN never; skip a refill -> UNDERRUN on 3rd word, SDO all 0.
- CS rises after 7 bits -> DONE + PARTIAL, DATA_OUT retains previous value, next frame starts at bit 0.
- RST asserted mid-frame with CS low -> outputs at reset values, remaining SCLK edges ignored, RX_VALID never until CS high then new frame.
- DATA_VALID asserted while TX_READY=0 -> holding unchanged, word not accepted.

Source files
------------

// File: rtl/spi_slave_burst_pkg.sv
// Shared definitions for the burst-capable SPI slave: FSM encodings and SPI mode helpers.
package spi_slave_burst_pkg;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } spi_state_e;

  localparam int SYNC_STAGES = 2;

  // CPHA=0 captures on the edge that leaves the idle level, CPHA=1 on the return edge.
  function automatic bit sample_on_lead(input bit cpha);
    return !cpha;
  endfunction

endpackage

// File: rtl/spi_slave_burst_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin; reset value chosen per pin.
module spi_sync_2ff #(
  parameter bit INIT = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave running entirely on CLK: oversampled SCLK/CS/SDI, all four modes,
// selectable bit order, back-to-back words per frame and a one-deep TX holding register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARM    | after reset; waits for a genuine CS high so a live frame is ignored
// ST_IDLE   | CS high, waiting for the next frame
// ST_ACTIVE | CS low, shifting words
module spi_slave_burst
  import spi_slave_burst_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DATA_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              RX_VALID,
  output logic              DONE,
  output logic              UNDERRUN,
  output logic              PARTIAL
);

  localparam int                CNT_W       = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(DATA_W - 1);
  localparam bit                SAMPLE_LEAD = sample_on_lead(CPHA);

  logic sclk_s, sclk_d, cs_s, sdi_s;
  logic [SYNC_STAGES-1:0] primed;

  spi_sync_2ff #(.INIT(CPOL)) u_sync_sclk (.CLK(CLK), .RST(RST), .d(SCLK), .q(sclk_s));
  spi_sync_2ff #(.INIT(1'b1)) u_sync_cs   (.CLK(CLK), .RST(RST), .d(CS),   .q(cs_s));
  spi_sync_2ff #(.INIT(1'b0)) u_sync_sdi  (.CLK(CLK), .RST(RST), .d(SDI),  .q(sdi_s));

  // The synchronisers come out of reset holding CS=1; primed marks when cs_s reflects the pin.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_d <= CPOL;
      primed <= '0;
    end else begin
      sclk_d <= sclk_s;
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == CPOL);
  assign trail_edge  = (sclk_s != sclk_d) && (sclk_d != CPOL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
  assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

  spi_state_e state, state_nxt;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_ARM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARM:    if (cs_s && primed[SYNC_STAGES-1]) state_nxt = ST_IDLE;
      ST_IDLE:   if (!cs_s) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (cs_s)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_ARM;
    endcase
  end

  logic [CNT_W-1:0] cnt, cnt_after, cnt_nxt;
  logic do_sample, word_end, do_shift, load_tx, frame_end;
  logic hold_full;

  always_comb begin
    do_sample = 1'b0;
    word_end  = 1'b0;
    do_shift  = 1'b0;
    load_tx   = 1'b0;
    frame_end = 1'b0;
    cnt_after = cnt;
    case (state)
      ST_IDLE: begin
        if (!cs_s) load_tx = 1'b1;
        cnt_after = '0;
      end
      ST_ACTIVE: begin
        if (sample_edge) begin
          do_sample = 1'b1;
          if (cnt == LAST_BIT) begin
            word_end  = 1'b1;
            cnt_after = '0;
            // A word finishing as the frame closes must not consume the holding register.
            load_tx   = !cs_s;
          end else begin
            cnt_after = cnt + CNT_W'(1);
          end
        end
        // cnt==0 marks the first shift edge of a word, whose bit is already on SDO.
        do_shift  = shift_edge && (cnt != '0);
        frame_end = cs_s;
      end
      default: ;
    endcase
    cnt_nxt = frame_end ? '0 : cnt_after;
  end

  logic [DATA_W-1:0] hold_reg, tx_sr, rx_sr, rx_word;
  logic accept;

  assign accept   = DATA_VALID && !hold_full;
  assign TX_READY = !hold_full;
  assign rx_word  = LSB_FIRST ? {sdi_s, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], sdi_s};
  assign SDO      = (state == ST_ACTIVE) && (LSB_FIRST ? tx_sr[0] : tx_sr[DATA_W-1]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      DATA_OUT  <= '0;
      RX_VALID  <= 1'b0;
      DONE      <= 1'b0;
      UNDERRUN  <= 1'b0;
      PARTIAL   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      RX_VALID <= word_end;
      DONE     <= frame_end;
      PARTIAL  <= frame_end && (cnt_after != '0);
      UNDERRUN <= load_tx && !hold_full;

      // Reload sees the old holding state; a same-cycle write refills it.
      if (accept) begin
        hold_reg  <= DATA_IN;
        hold_full <= 1'b1;
      end else if (load_tx) begin
        hold_full <= 1'b0;
      end

      if (load_tx)       tx_sr <= hold_full ? hold_reg : '0;
      else if (do_shift) tx_sr <= LSB_FIRST ? (tx_sr >> 1) : (tx_sr << 1);

      if (do_sample) rx_sr    <= rx_word;
      if (word_end)  DATA_OUT <= rx_word;
    end
  end

endmodule
